// File: rtl/decode_stage.sv
// Instruction decode pipeline stage: one-deep output register with valid/ready
// handshake, RUN/HALTED control FSM, opcode one-hot and control decode.
// Ports: clk_pi, reset_pi (sync, active-high); instruction_pi/in_valid_pi/
// in_ready_po in; out_valid_po/out_ready_pi out with alu_func_po, dest/src1/
// src2_reg_po, immediate_po, op_onehot_po, ctrl_po, illegal_po; resume_pi and
// halted_po for the halt FSM. Optional macro: DECODE_ILLEGAL_TRAP_EN.

package decode_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam int OP_ARITH2 = 0;
  localparam int OP_ARITH1 = 1;
  localparam int OP_MOVILO = 2;
  localparam int OP_MOVIHI = 3;
  localparam int OP_ADDI   = 4;
  localparam int OP_SUBI   = 5;
  localparam int OP_LOAD   = 6;
  localparam int OP_STORE  = 7;
  localparam int OP_BEQ    = 8;
  localparam int OP_BGE    = 9;
  localparam int OP_BLE    = 10;
  localparam int OP_BC     = 11;
  localparam int OP_JUMP   = 12;

  localparam int CT_STC  = 0;
  localparam int CT_STB  = 1;
  localparam int CT_HALT = 2;
  localparam int CT_RST  = 3;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk_pi,
  input  logic                  reset_pi,
  input  logic [INSTR_W-1:0]    instruction_pi,
  input  logic                  in_valid_pi,
  output logic                  in_ready_po,
  input  logic                  resume_pi,
  output logic                  out_valid_po,
  input  logic                  out_ready_pi,
  output logic [2:0]            alu_func_po,
  output logic [REG_ADDR_W-1:0] dest_reg_po,
  output logic [REG_ADDR_W-1:0] src1_reg_po,
  output logic [REG_ADDR_W-1:0] src2_reg_po,
  output logic [INSTR_W-5:0]    immediate_po,
  output logic [12:0]           op_onehot_po,
  output logic [3:0]            ctrl_po,
  output logic                  halted_po,
  output logic                  illegal_po
);

  localparam int IMM_W = INSTR_W - 4;
  localparam int R     = REG_ADDR_W;

  // 1010...: set on every other bit counting down from the MSB
  function automatic logic [IMM_W-1:0] alt_pat();
    logic [IMM_W-1:0] p;
    p = '0;
    for (int i = 0; i < IMM_W; i++) begin
      p[i] = ((IMM_W - 1 - i) % 2) == 0;
    end
    return p;
  endfunction

  localparam logic [IMM_W-1:0] IMM_STC = IMM_W'(1);
  localparam logic [IMM_W-1:0] IMM_STB = IMM_W'(2);
  localparam logic [IMM_W-1:0] IMM_HLT = '1;
  localparam logic [IMM_W-1:0] IMM_RST = alt_pat();

  logic [3:0]       op;
  logic [IMM_W-1:0] imm;
  logic             movi_msb;

  assign op       = instruction_pi[INSTR_W-1 -: 4];
  assign imm      = instruction_pi[IMM_W-1:0];
  assign movi_msb = instruction_pi[IMM_W-1-R];

  logic [12:0] d_oh;
  logic [3:0]  d_ctrl;
  logic [2:0]  d_alu;
  logic        d_ill;

  always_comb begin
    d_oh   = '0;
    d_ctrl = '0;
    d_alu  = '0;
    d_ill  = 1'b0;
    unique case (op)
      4'h1: begin
        d_oh[OP_ARITH2] = 1'b1;
        d_alu           = instruction_pi[2:0];
      end
      4'h2: begin
        d_oh[OP_ARITH1] = 1'b1;
        d_alu           = instruction_pi[2:0];
      end
      4'h3: begin
        d_oh[OP_MOVIHI] = movi_msb;
        d_oh[OP_MOVILO] = !movi_msb;
      end
      4'h4: d_oh[OP_ADDI]  = 1'b1;
      4'h5: d_oh[OP_SUBI]  = 1'b1;
      4'h6: d_oh[OP_LOAD]  = 1'b1;
      4'h7: d_oh[OP_STORE] = 1'b1;
      4'h8: d_oh[OP_BEQ]   = 1'b1;
      4'h9: d_oh[OP_BGE]   = 1'b1;
      4'hA: d_oh[OP_BLE]   = 1'b1;
      4'hB: d_oh[OP_BC]    = 1'b1;
      4'hC: d_oh[OP_JUMP]  = 1'b1;
      4'hD, 4'hE: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        d_ill = 1'b1;
`endif
      end
      4'hF: begin
        unique case (1'b1)
          (imm == IMM_STC): d_ctrl[CT_STC]  = 1'b1;
          (imm == IMM_STB): d_ctrl[CT_STB]  = 1'b1;
          (imm == IMM_HLT): d_ctrl[CT_HALT] = 1'b1;
          (imm == IMM_RST): d_ctrl[CT_RST]  = 1'b1;
          default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            d_ill = 1'b1;
`endif
          end
        endcase
      end
      default: ;
    endcase
  end

  state_t state;
  state_t state_nx;

  logic             vld_q;
  logic [12:0]      oh_q;
  logic [3:0]       ctrl_q;
  logic [2:0]       alu_q;
  logic             ill_q;
  logic [R-1:0]     dest_q;
  logic [R-1:0]     src1_q;
  logic [R-1:0]     src2_q;
  logic [IMM_W-1:0] imm_q;
  logic             accept;

  assign in_ready_po = (!vld_q || out_ready_pi) && (state == RUN);
  assign accept      = in_valid_pi && in_ready_po;

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (accept && d_ctrl[CT_HALT]) state_nx = HALTED;
      end
      HALTED: begin
        if (resume_pi) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state  <= RUN;
      vld_q  <= 1'b0;
      oh_q   <= '0;
      ctrl_q <= '0;
      alu_q  <= '0;
      ill_q  <= 1'b0;
      dest_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      imm_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vld_q  <= 1'b1;
        oh_q   <= d_oh;
        ctrl_q <= d_ctrl;
        alu_q  <= d_alu;
        ill_q  <= d_ill;
        dest_q <= instruction_pi[IMM_W-1 -: R];
        src1_q <= instruction_pi[IMM_W-1-R -: R];
        src2_q <= instruction_pi[IMM_W-1-2*R -: R];
        imm_q  <= imm;
      end else if (out_ready_pi) begin
        vld_q <= 1'b0;
      end
    end
  end

  // Flag outputs read as zero whenever no word is presented
  assign out_valid_po = vld_q;
  assign op_onehot_po = oh_q & {13{vld_q}};
  assign ctrl_po      = ctrl_q & {4{vld_q}};
  assign alu_func_po  = alu_q & {3{vld_q}};
  assign illegal_po   = ill_q & vld_q;
  assign dest_reg_po  = dest_q;
  assign src1_reg_po  = src1_q;
  assign src2_reg_po  = src2_q;
  assign immediate_po = imm_q;
  assign halted_po    = (state == HALTED);

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width in bits; SHALL satisfy INSTR_W >= 7 + 3*REG_ADDR_W.
REQ-002 Parameter REG_ADDR_W, default 3, register-index width in bits.
REQ-003 clk_pi  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_pi  in  1  synchronous, active-high reset.
REQ-005 instruction_pi  in  INSTR_W  instruction word; opcode = top 4 bits.
REQ-006 in_valid_pi  in  1  instruction_pi is valid.
REQ-007 in_ready_po  out  1  stage accepts an instruction this cycle.
REQ-008 resume_pi  in  1  leave HALTED state.
REQ-009 out_valid_po  out  1  decoded word is valid.
REQ-010 out_ready_pi  in  1  downstream consumes the decoded word.
REQ-011 alu_func_po  out  3  ALU function, equal to instruction bits [2:0].
REQ-012 dest_reg_po / src1_reg_po / src2_reg_po  out  REG_ADDR_W each  consecutive fields directly below the opcode, in order dest, src1, src2.
REQ-013 immediate_po  out  INSTR_W-4  all instruction bits below the opcode.
REQ-014 op_onehot_po  out  13  bits [0..12] = arith2, arith1, movi_lo, movi_hi, addi, subi, load, store, beq, bge, ble, bc, jump.
REQ-015 ctrl_po  out  4  bits [0..3] = stc, stb, halt, rst.
REQ-016 halted_po  out  1  stage is in HALTED state.
REQ-017 illegal_po  out  1  decoded word is an illegal instruction.

Function
REQ-018 Opcode map SHALL be: 0 NOP, 1 ARITH_2OP, 2 ARITH_1OP, 3 MOVI, 4 ADDI, 5 SUBI, 6 LOAD, 7 STOR, 8 BEQ, 9 BGE, A BLE, B BC, C J, F CONTROL.
REQ-019 MOVI SHALL set movi_hi when the MSB of the src1 field is 1, and movi_lo when it is 0.
REQ-020 CONTROL immediate SHALL decode over INSTR_W-4 bits: value 1 -> stc, value 2 -> stb, all-ones -> halt, alternating pattern with MSB=1 (1010...) -> rst.
REQ-021 alu_func_po SHALL be instruction[2:0] for ARITH_2OP and ARITH_1OP, and 0 for every other opcode.
REQ-022 Transfer SHALL occur when in_valid_pi && in_ready_po; the decoded word SHALL appear with out_valid_po=1 on the next cycle (latency 1).
REQ-023 in_ready_po SHALL equal (!out_valid_po || out_ready_pi) && state==RUN, computed combinationally.
REQ-024 While out_valid_po && !out_ready_pi, every output SHALL hold stable.
REQ-025 When out_valid_po=0, op_onehot_po, ctrl_po, alu_func_po and illegal_po SHALL be 0; field outputs are don't-care.
REQ-026 Simultaneous consume and accept in one cycle SHALL replace the output word with no bubble.
REQ-027 FSM states are RUN and HALTED. Acceptance of a halt instruction SHALL move the FSM to HALTED on the same edge that registers the word.
REQ-028 In HALTED, in_ready_po=0 and halted_po=1. The pending halt word SHALL still drain normally.
REQ-029 In HALTED, resume_pi=1 SHALL return the FSM to RUN on the next edge. resume_pi in RUN SHALL be ignored.
REQ-030 An accepted rst instruction SHALL be emitted with ctrl_po[3]=1 and cause no internal state change.
REQ-031 NOP and unrecognised CONTROL immediates SHALL emit all-zero op_onehot_po and ctrl_po.

Reset
REQ-032 While reset_pi=1 at a clock edge: out_valid_po=0, all decoded outputs=0, FSM=RUN, halted_po=0. Reset SHALL take priority over every other event, including a mid-transfer or HALTED state.

Configuration
REQ-033 Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: opcodes D and E, and CONTROL with an unrecognised immediate, SHALL set illegal_po=1 on the emitted word.
- Undefined: illegal_po SHALL be tied to 0, and those encodings SHALL decode as NOP.

Verification
REQ-034 Reset, then 0x1A53 with out_ready=1 -> next cycle out_valid=1, arith2, dest=5, src1=1, src2=2, alu_func=3.
REQ-035 0x3100 then 0x3000 back-to-back -> movi_hi then movi_lo on consecutive cycles, in_ready held at 1.
REQ-036 out_ready=0 for 3 cycles with an ADDI word pending -> outputs stable, in_ready=0; release -> next word accepted in the same cycle.
REQ-037 0xFFFF accepted -> ctrl halt emitted, halted_po=1, in_ready=0; resume_pi pulse -> in_ready=1 on the next cycle.
REQ-038 0xFAAA -> ctrl_po=4'b1000; 0xD000 -> illegal_po=1 with the macro defined, all flags 0 without it.
REQ-039 reset_pi asserted while HALTED with a word pending -> out_valid=0, halted_po=0, in_ready=1 on the next cycle.
